// File: rtl/adc_capture_multi_pkg.sv
// Shared definitions for the multi-channel serial ADC capture front end:
// the FSM state encoding and a width helper used for counters and pointers.
package adc_capture_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIET   = 2'd1,
    ST_CONVERT = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_capture_multi_sync_fifo.sv
// Single-clock FIFO holding packed capture words until the consumer takes them.
// Pointers carry one extra bit so a full FIFO can be told apart from an empty one.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module adc_capture_multi_sync_fifo
  import adc_capture_multi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = count_width(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Advance the read and write pointers; they wrap naturally at their width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the empty flag hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/adc_capture_multi.sv
// Serial ADC capture front end. Frames a shared active-low chip select,
// shifts CHANNELS serial data lines MSB-first, packs one sample per channel
// into a word (channel 0 in the LSBs) and queues words for a valid/ready
// consumer. Words arriving at a full FIFO are dropped and counted.
module adc_capture_multi
  import adc_capture_multi_pkg::*;
#(
  parameter int CHANNELS     = 1,
  parameter int SAMPLE_BITS  = 12,
  parameter int LEAD_BITS    = 2,
  parameter int FRAME_CYCLES = 16,
  parameter int IDLE_CYCLES  = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk48,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            trigger,
  output logic                            adc_cs,
  input  logic [CHANNELS-1:0]             adc_sdo,
  output logic [CHANNELS*SAMPLE_BITS-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overrun,
  output logic [7:0]                      drop_count,
  output logic                            busy
);

  localparam int WORD_BITS = CHANNELS * SAMPLE_BITS;
  localparam int KW        = count_width(FRAME_CYCLES);
  localparam int QW        = count_width(IDLE_CYCLES);

  localparam logic [KW-1:0] K_LAST  = KW'(FRAME_CYCLES - 1);
  localparam logic [KW-1:0] K_ONE   = KW'(1);
  localparam logic [QW-1:0] Q_LAST  = QW'(IDLE_CYCLES - 1);
  localparam logic [QW-1:0] Q_ONE   = QW'(1);
  // One extra bit so the window end can equal FRAME_CYCLES without wrapping.
  localparam logic [KW:0]   WIN_LO  = (KW+1)'(LEAD_BITS);
  localparam logic [KW:0]   WIN_HI  = (KW+1)'(LEAD_BITS + SAMPLE_BITS);

  state_t                                 state;
  logic [KW-1:0]                          bit_cnt;
  logic [QW-1:0]                          quiet_cnt;
  logic [CHANNELS-1:0][SAMPLE_BITS-1:0]   shreg;
  logic [CHANNELS-1:0][SAMPLE_BITS-1:0]   shift_next;
  logic [KW:0]                            bit_ext;
  logic                                   in_window;
  logic                                   push;
  logic                                   pop;
  logic                                   drop;
  logic                                   fifo_full;
  logic                                   fifo_empty;
  logic [WORD_BITS-1:0]                   push_word;

  assign bit_ext   = {1'b0, bit_cnt};
  assign in_window = (state == ST_CONVERT) && (bit_ext >= WIN_LO) && (bit_ext < WIN_HI);
  assign push      = (state == ST_CONVERT) && (bit_cnt == K_LAST);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push && fifo_full && !pop;
  // The pushed word includes any bit sampled on the final edge of the frame.
  assign push_word = shift_next;

  // Frame sequencer: idle, chip-select quiet gap, then the converting window.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      adc_cs    <= 1'b1;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      quiet_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable || trigger) begin
            state     <= ST_QUIET;
            busy      <= 1'b1;
            quiet_cnt <= '0;
          end
        end
        ST_QUIET: begin
          if (quiet_cnt == Q_LAST) begin
            state   <= ST_CONVERT;
            adc_cs  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + Q_ONE;
          end
        end
        ST_CONVERT: begin
          if (bit_cnt == K_LAST) begin
            adc_cs    <= 1'b1;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            if (enable) begin
              state <= ST_QUIET;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + K_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          adc_cs <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Next shift-register contents: data bits inside the sample window enter MSB-first.
  always_comb begin
    shift_next = shreg;
    if (in_window) begin
      for (int c = 0; c < CHANNELS; c++) begin
        shift_next[c] = (shreg[c] << 1) | SAMPLE_BITS'(adc_sdo[c]);
      end
    end
  end

  // Per-channel shift registers; reset discards any partial frame.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) shreg <= '0;
    else       shreg <= shift_next;
  end

  // Sticky overrun flag and saturating count of words lost to a full FIFO.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  adc_capture_multi_sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk48),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (out_data),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_adc_capture_multi.sv
// Bench for adc_capture_multi: an ADC model serves per-frame samples, and a
// queue-based reference of the output FIFO predicts every output word,
// the overrun flag and the drop count, alongside directed corner cases.
module tb_adc_capture_multi;

  localparam int CH    = 2;
  localparam int SB    = 12;
  localparam int LEAD  = 2;
  localparam int FRAME = 16;
  localparam int IDLE  = 2;
  localparam int DEPTH = 4;
  localparam int WB    = CH * SB;

  logic          clk48     = 1'b0;
  logic          reset     = 1'b0;
  logic          enable    = 1'b0;
  logic          trigger   = 1'b0;
  logic          out_ready = 1'b0;
  logic [CH-1:0] adc_sdo   = '0;
  logic          adc_cs;
  logic [WB-1:0] out_data;
  logic          out_valid;
  logic          overrun;
  logic [7:0]    drop_count;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  // ADC model and reference state, owned by the negedge monitor
  logic          rand_vals = 1'b0;
  logic [SB-1:0] fix0 = '0;
  logic [SB-1:0] fix1 = '0;
  logic [SB-1:0] cur_val [CH];
  logic [WB-1:0] cur_word;
  logic [WB-1:0] model_q [$];
  logic [WB-1:0] sent_q  [$];
  logic [WB-1:0] pop_q   [$];
  int            model_drops = 0;
  int            lowcnt      = 0;
  int            highcnt     = 0;
  int            frame_count = 0;
  int            kk;
  int            bi;
  logic          pop_now;
  logic          push_now;

  typedef struct {
    logic [SB-1:0] ch0;
    logic [SB-1:0] ch1;
    logic [WB-1:0] word;
  } vec_t;
  vec_t vecs [5];

  adc_capture_multi #(
    .CHANNELS     (CH),
    .SAMPLE_BITS  (SB),
    .LEAD_BITS    (LEAD),
    .FRAME_CYCLES (FRAME),
    .IDLE_CYCLES  (IDLE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk48      (clk48),
    .reset      (reset),
    .enable     (enable),
    .trigger    (trigger),
    .adc_cs     (adc_cs),
    .adc_sdo    (adc_sdo),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk48 = ~clk48;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic trg, input logic rdy);
    enable    = en;
    trigger   = trg;
    out_ready = rdy;
    tick();
  endtask

  task automatic applyReset();
    reset   = 1'b1;
    enable  = 1'b0;
    trigger = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sent_q.delete();
    pop_q.delete();
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    if (busy !== 1'b0) checkOutput("wait_idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic waitFrames(input int target, input int min_low, input int budget);
    int n = 0;
    while (!(frame_count >= target && lowcnt >= min_low) && n < budget) begin tick(); n++; end
    if (!(frame_count >= target && lowcnt >= min_low))
      checkOutput("wait_frames_timeout", 64'(frame_count), 64'(target));
  endtask

  task automatic waitLow(input int target, input int budget);
    int n = 0;
    while (lowcnt != target && n < budget) begin tick(); n++; end
    if (lowcnt != target) checkOutput("wait_low_timeout", 64'(lowcnt), 64'(target));
  endtask

  // ADC model plus reference FIFO, evaluated mid-cycle away from the active edge.
  always @(negedge clk48) begin
    if (reset) begin
      model_q.delete();
      model_drops = 0;
      lowcnt      = 0;
      highcnt     = 0;
      adc_sdo     = '0;
    end else begin
      checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      if (model_q.size() > 0) checkOutput("out_data", 64'(out_data), 64'(model_q[0]));
      checkOutput("overrun", 64'(overrun), 64'(model_drops > 0));
      checkOutput("drop_count", 64'(drop_count), 64'(model_drops));
      pop_now  = (model_q.size() > 0) && out_ready;
      push_now = 1'b0;
      if (out_valid && out_ready) pop_q.push_back(out_data);
      if (adc_cs === 1'b0) begin
        if (lowcnt == 0) begin
          checkOutput("cs_high_run_min", 64'(highcnt >= IDLE), 64'(1));
          for (int c = 0; c < CH; c++) cur_val[c] = rand_vals ? SB'($urandom) : ((c == 0) ? fix0 : fix1);
          for (int c = 0; c < CH; c++) cur_word[c*SB +: SB] = cur_val[c];
        end
        lowcnt++;
        kk = lowcnt - 1;
        for (int c = 0; c < CH; c++) begin
          if (kk < LEAD) adc_sdo[c] = 1'b0;
          else if (kk < LEAD + SB) begin
            bi = SB - 1 - (kk - LEAD);
            adc_sdo[c] = cur_val[c][bi];
          end else adc_sdo[c] = 1'b1;
        end
        if (lowcnt == FRAME) begin
          push_now = 1'b1;
          sent_q.push_back(cur_word);
          frame_count++;
        end
      end else begin
        if (lowcnt != 0) begin
          checkOutput("cs_low_run", 64'(lowcnt), 64'(FRAME));
          highcnt = 0;
        end
        lowcnt = 0;
        highcnt++;
        adc_sdo = '0;
      end
      if (pop_now) void'(model_q.pop_front());
      if (push_now) begin
        if (model_q.size() < DEPTH) model_q.push_back(cur_word);
        else if (model_drops < 255) model_drops++;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int pulses [$];

    vecs[0] = '{ch0: 12'hA5C, ch1: 12'h3F1, word: 24'h3F1A5C};
    vecs[1] = '{ch0: 12'h000, ch1: 12'hFFF, word: 24'hFFF000};
    vecs[2] = '{ch0: 12'hFFF, ch1: 12'h000, word: 24'h000FFF};
    vecs[3] = '{ch0: 12'h800, ch1: 12'h001, word: 24'h001800};
    vecs[4] = '{ch0: 12'h123, ch1: 12'hABC, word: 24'hABC123};

    // Reset values
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_adc_cs", 64'(adc_cs), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_overrun", 64'(overrun), 64'(0));
    checkOutput("rst_drop_count", 64'(drop_count), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    tick();
    tick();
    reset = 1'b0;

    // Continuous mode with fixed samples: one word every 18 cycles
    $display("[TB] continuous capture");
    fix0 = 12'hA5C;
    fix1 = 12'h3F1;
    out_ready = 1'b1;
    enable = 1'b1;
    for (int n = 0; n < 200 && pulses.size() < 4; n++) begin
      tick();
      if (out_valid === 1'b1) begin
        pulses.push_back(n);
        checkOutput("cont_word", 64'(out_data), 64'(24'h3F1A5C));
        checkOutput("cont_busy", 64'(busy), 64'(1));
      end
    end
    checkOutput("cont_pulses", 64'(pulses.size()), 64'(4));
    for (int i = 1; i < pulses.size(); i++)
      checkOutput("cont_period", 64'(pulses[i] - pulses[i-1]), 64'(IDLE + FRAME));
    enable = 1'b0;
    waitIdle(100);

    // Table of single-shot frames
    $display("[TB] single-shot vector table");
    applyReset();
    for (int i = 0; i < 5; i++) begin
      fix0 = vecs[i].ch0;
      fix1 = vecs[i].ch1;
      pop_q.delete();
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitIdle(100);
      repeat (3) tick();
      checkOutput("vec_count", 64'(pop_q.size()), 64'(1));
      if (pop_q.size() > 0) checkOutput("vec_word", 64'(pop_q[pop_q.size()-1]), 64'(vecs[i].word));
    end

    // Trigger mid-frame is ignored
    $display("[TB] trigger during frame");
    applyReset();
    fix0 = 12'hA5C;
    fix1 = 12'h3F1;
    base = frame_count;
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitLow(5, 100);
    checkOutput("trig_busy_mid", 64'(busy), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle(100);
    repeat (40) tick();
    checkOutput("trig_frames", 64'(frame_count - base), 64'(1));
    checkOutput("trig_words", 64'(pop_q.size()), 64'(1));
    if (pop_q.size() > 0) checkOutput("trig_word", 64'(pop_q[0]), 64'(24'h3F1A5C));
    checkOutput("trig_cs_idle", 64'(adc_cs), 64'(1));

    // Six frames into a stalled four-entry FIFO
    $display("[TB] overrun");
    applyReset();
    rand_vals = 1'b1;
    base = frame_count;
    out_ready = 1'b0;
    enable = 1'b1;
    waitFrames(base + 5, 3, 400);
    enable = 1'b0;
    waitIdle(100);
    checkOutput("ovr_frames", 64'(frame_count - base), 64'(6));
    checkOutput("ovr_flag", 64'(overrun), 64'(1));
    checkOutput("ovr_drops", 64'(drop_count), 64'(2));
    out_ready = 1'b1;
    repeat (10) tick();
    checkOutput("ovr_drained", 64'(pop_q.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      if (i < pop_q.size()) checkOutput("ovr_order", 64'(pop_q[i]), 64'(sent_q[i]));
    checkOutput("ovr_flag_sticky", 64'(overrun), 64'(1));

    // Full FIFO with a pop on the push cycle accepts the push
    $display("[TB] push and pop on full");
    applyReset();
    base = frame_count;
    out_ready = 1'b0;
    enable = 1'b1;
    waitFrames(base + 4, 3, 400);
    enable = 1'b0;
    waitLow(15, 40);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    waitIdle(100);
    checkOutput("full_pop_drops", 64'(drop_count), 64'(0));
    checkOutput("full_pop_overrun", 64'(overrun), 64'(0));
    out_ready = 1'b1;
    repeat (10) tick();
    checkOutput("full_pop_words", 64'(pop_q.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < pop_q.size()) checkOutput("full_pop_order", 64'(pop_q[i]), 64'(sent_q[i]));

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    applyReset();
    base = frame_count;
    out_ready = 1'b1;
    enable = 1'b1;
    waitLow(7, 100);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    checkOutput("midrst_cs", 64'(adc_cs), 64'(1));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_valid", 64'(out_valid), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    pop_q.delete();
    repeat (40) tick();
    checkOutput("midrst_frames", 64'(frame_count - base), 64'(0));
    checkOutput("midrst_words", 64'(pop_q.size()), 64'(0));
    checkOutput("midrst_cs_after", 64'(adc_cs), 64'(1));

    // Enable dropped early in a frame: the frame completes, then idle
    $display("[TB] enable dropped mid-frame");
    applyReset();
    base = frame_count;
    out_ready = 1'b1;
    enable = 1'b1;
    waitLow(3, 100);
    enable = 1'b0;
    waitIdle(100);
    repeat (40) tick();
    checkOutput("endrop_frames", 64'(frame_count - base), 64'(1));
    checkOutput("endrop_words", 64'(pop_q.size()), 64'(1));
    if (pop_q.size() > 0 && sent_q.size() > 0) checkOutput("endrop_word", 64'(pop_q[0]), 64'(sent_q[0]));
    checkOutput("endrop_cs", 64'(adc_cs), 64'(1));
    checkOutput("endrop_busy", 64'(busy), 64'(0));

    // Randomized traffic against the reference
    $display("[TB] random traffic");
    applyReset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      trigger   = ($urandom_range(0, 15) == 0);
      out_ready = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    enable = 1'b0;
    trigger = 1'b0;
    waitIdle(100);
    out_ready = 1'b1;
    repeat (10) tick();
    checkOutput("rand_final_empty", 64'(out_valid), 64'(0));

    // Drop counter saturation
    $display("[TB] drop count saturation");
    applyReset();
    base = frame_count;
    out_ready = 1'b0;
    enable = 1'b1;
    waitFrames(base + 262, 0, 5200);
    enable = 1'b0;
    waitIdle(100);
    checkOutput("sat_drops", 64'(drop_count), 64'(255));
    checkOutput("sat_overrun", 64'(overrun), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
